// File: rtl/uart_rx_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : uart_rx_ctrl_pkg                                           |
// | Description : Shared types and constants for the uart_rx controller:     |
// |               config FSM state type, defaults shared with uart_rx and    |
// |               the maximum programmable baud rate helper.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_rx_ctrl_pkg;

  // Defaults shared with the uart_rx receiver instance
  localparam int unsigned c_DEF_FREQ_CLK  = 100_000_000;
  localparam int unsigned c_DEF_DATA_WDTH = 8;
  localparam int unsigned c_DEF_BAUD      = 115_200;

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    IDLE    = 3'd1,
    WAIT_RX = 3'd2,
    WRITE   = 3'd3,
    READ    = 3'd4,
    SETTLE  = 3'd5
  } cfg_state_t;

  // Highest baud rate the receiver can oversample: a quarter of the clock.
  function automatic logic [31:0] max_baud(input int unsigned freq_clk);
    return 32'(freq_clk / 4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : uart_rx_ctrl_if                                            |
// | Description : Bundles the host config handshake, the uart_rx control /   |
// |               status lines and the receive FIFO pop port. Suffixes are   |
// |               as seen from the controller (slave modport).               |
// |   cfg_*  : host baud request (valid/ready) plus done/err pulses          |
// |   baud_* : baud value and write/read strobes towards uart_rx             |
// |   rx_*   : receiver idle, frame-done level and frame data               |
// |   rd_*   : FIFO head with valid/ready pop                               |
// |   ovf_*  : sticky overflow flag and its clear                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface uart_rx_ctrl_if
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WDTH = c_DEF_DATA_WDTH
) ();

  logic                 cfg_valid_i;
  logic [31:0]          cfg_baud_i;
  logic                 cfg_ready_o;
  logic                 cfg_done_o;
  logic                 cfg_err_o;
  logic [31:0]          baud_rate_o;
  logic                 baud_we_o;
  logic                 baud_rd_o;
  logic                 rx_ready_i;
  logic                 rx_done_i;
  logic [DATA_WDTH-1:0] rx_data_i;
  logic                 rd_valid_o;
  logic                 rd_ready_i;
  logic [DATA_WDTH-1:0] rd_data_o;
  logic                 ovf_o;
  logic                 ovf_clr_i;

  modport slave (
    input  cfg_valid_i, cfg_baud_i, rx_ready_i, rx_done_i, rx_data_i,
           rd_ready_i, ovf_clr_i,
    output cfg_ready_o, cfg_done_o, cfg_err_o, baud_rate_o, baud_we_o,
           baud_rd_o, rd_valid_o, rd_data_o, ovf_o
  );

  modport master (
    output cfg_valid_i, cfg_baud_i, rx_ready_i, rx_done_i, rx_data_i,
           rd_ready_i, ovf_clr_i,
    input  cfg_ready_o, cfg_done_o, cfg_err_o, baud_rate_o, baud_we_o,
           baud_rd_o, rd_valid_o, rd_data_o, ovf_o
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_ctrl_fifo                                          |
// | Description : DATA_WDTH x FIFO_DEPTH synchronous FIFO with a             |
// |               combinational head. A push while full is accepted only     |
// |               when a pop frees the slot in the same cycle.               |
// |   clk, rst : clock, asynchronous active-high reset                       |
// |   push_i   : write data_i                                                |
// |   pop_i    : discard head (ignored when empty)                           |
// |   full_o, empty_o, head_o : status and head entry                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_ctrl_fifo #(
  parameter int unsigned DATA_WDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DATA_WDTH-1:0] data_i,
  output logic                 full_o,
  input  logic                 pop_i,
  output logic [DATA_WDTH-1:0] head_o,
  output logic                 empty_o
);

  localparam int unsigned c_AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [c_AW:0]          wr_ptr_q;
  logic [c_AW:0]          rd_ptr_q;
  logic [DATA_WDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                   w_rd_en;
  logic                   w_wr_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                   (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[c_AW-1:0]];

  assign w_rd_en = pop_i & ~empty_o;
  assign w_wr_en = push_i & (~full_o | w_rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        mem_q[wr_ptr_q[c_AW-1:0]] <= data_i;
        wr_ptr_q                  <= wr_ptr_q + 1'b1;
      end
      if (w_rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_ctrl                                               |
// | Description : Sequencing wrapper for one uart_rx receiver. Programs the  |
// |               baud rate after reset and on host request (only while the  |
// |               receiver is idle), captures each completed frame into a    |
// |               small FIFO and flags overflow / rejected requests.         |
// |   clk, rst : clock, asynchronous active-high reset                       |
// |   bus      : uart_rx_ctrl_if.slave (config, uart_rx lines, FIFO pop)     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned FREQ_CLK     = c_DEF_FREQ_CLK,
  parameter int unsigned DATA_WDTH    = c_DEF_DATA_WDTH,
  parameter int unsigned DEFAULT_BAUD = c_DEF_BAUD,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned HOLD_CYC     = 4,
  parameter int unsigned IDLE_TMO     = 65535
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);

  localparam logic [31:0] c_MAX_BAUD  = max_baud(FREQ_CLK);
  localparam int unsigned c_HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned c_TW        = $clog2(IDLE_TMO + 1);
  localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_CYC - 1);
  localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(IDLE_TMO - 1);

  cfg_state_t       state_q, state_d;
  logic [c_HW-1:0]  hold_q, hold_d;
  logic [c_TW-1:0]  tmo_q, tmo_d;
  logic [31:0]      baud_q, baud_d;
  logic [31:0]      req_q, req_d;
  logic             boot_q, boot_d;       // current sequence came from BOOT
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             done_q;               // previous RX_DONE level
  logic             ovf_q, ovf_d;

  logic             w_hold_end;
  logic             w_baud_bad;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf_set;

  // ---------------------------------------------------------------- config FSM
  assign w_hold_end = (hold_q == c_HOLD_LAST);
  assign w_baud_bad = (bus.cfg_baud_i == 32'd0) || (bus.cfg_baud_i > c_MAX_BAUD);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    baud_d     = baud_q;
    req_d      = req_q;
    boot_d     = boot_q;
    cfg_done_d = 1'b0;
    cfg_err_d  = 1'b0;
    case (state_q)
      BOOT: begin
        baud_d  = 32'(DEFAULT_BAUD);
        boot_d  = 1'b1;
        hold_d  = '0;
        state_d = WRITE;
      end
      IDLE: begin
        if (bus.cfg_valid_i) begin
          req_d = bus.cfg_baud_i;
          if (w_baud_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            tmo_d   = '0;
            state_d = WAIT_RX;
          end
        end
      end
      WAIT_RX: begin
        // Receiver idle wins over a timeout landing on the same cycle.
        if (bus.rx_ready_i) begin
          baud_d  = req_q;
          hold_d  = '0;
          state_d = WRITE;
        end else if (tmo_q == c_TMO_LAST) begin
          cfg_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WRITE, READ: begin
        if (w_hold_end) begin
          hold_d  = '0;
          state_d = (state_q == WRITE) ? READ : SETTLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      SETTLE: begin
        if (w_hold_end) begin
          hold_d     = '0;
          cfg_done_d = ~boot_q;
          boot_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      hold_q     <= '0;
      tmo_q      <= '0;
      baud_q     <= 32'(DEFAULT_BAUD);
      req_q      <= '0;
      boot_q     <= 1'b1;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tmo_q      <= tmo_d;
      baud_q     <= baud_d;
      req_q      <= req_d;
      boot_q     <= boot_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign bus.cfg_ready_o = (state_q == IDLE);
  assign bus.cfg_done_o  = cfg_done_q;
  assign bus.cfg_err_o   = cfg_err_q;
  assign bus.baud_rate_o = baud_q;
  assign bus.baud_we_o   = (state_q == WRITE);
  assign bus.baud_rd_o   = (state_q == READ);

  // ----------------------------------------------------------- frame capture
  // DONE is a level held until the receiver idles, so only its rising edge
  // produces a FIFO entry.
  assign w_push = bus.rx_done_i & ~done_q;

  // Full implies non-empty, so a concurrent ready always frees a slot.
  assign w_ovf_set = w_push & w_full & ~bus.rd_ready_i;
  assign ovf_d     = w_ovf_set | (ovf_q & ~bus.ovf_clr_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= bus.rx_done_i;
      ovf_q  <= ovf_d;
    end
  end

  uart_rx_ctrl_fifo #(
    .DATA_WDTH  (DATA_WDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (bus.rx_data_i),
    .full_o  (w_full),
    .pop_i   (bus.rd_ready_i),
    .head_o  (bus.rd_data_o),
    .empty_o (w_empty)
  );

  assign bus.rd_valid_o = ~w_empty;
  assign bus.ovf_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_ctrl                                            |
// | Description : Self-checking bench for uart_rx_ctrl: a cycle model of the |
// |               config sequence and receive FIFO compared on every cycle,  |
// |               plus directed scenarios with literal expectations.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_ctrl;

  localparam int          H        = 4;
  localparam int          TMO      = 16;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] DEF_BAUD = 32'd115200;
  localparam logic [31:0] MAXB     = 32'd25_000_000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  uart_rx_ctrl_if #(.DATA_WDTH(8)) bus ();

  uart_rx_ctrl #(
    .FREQ_CLK     (100_000_000),
    .DATA_WDTH    (8),
    .DEFAULT_BAUD (115200),
    .FIFO_DEPTH   (4),
    .HOLD_CYC     (4),
    .IDLE_TMO     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'd0, act}, {31'd0, exp});
  endtask

  // ------------------------------------------------------------------ model
  // Config progress is tracked as "cycles since the write strobe started"
  // (m_seq) or "cycles spent waiting for the receiver" (m_wait).
  bit          m_boot;
  int          m_seq;
  bit          m_from_boot;
  int          m_wait;
  logic [31:0] m_req;
  logic [31:0] m_baud;
  bit          m_done;
  bit          m_err;
  logic [7:0]  m_q[$];
  bit          m_ovf;
  bit          m_prev;

  task automatic model_reset();
    m_boot = 1; m_seq = -1; m_from_boot = 0; m_wait = -1;
    m_req = '0; m_baud = DEF_BAUD; m_done = 0; m_err = 0;
    m_q.delete(); m_ovf = 0; m_prev = 0;
  endtask

  task automatic model_step();
    bit push, pop, lost;
    push   = bus.rx_done_i && !m_prev;
    m_prev = bus.rx_done_i;
    pop    = bus.rd_ready_i && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    lost = push && (m_q.size() >= DEPTH);
    if (push && !lost) m_q.push_back(bus.rx_data_i);
    if (lost) m_ovf = 1;
    else if (bus.ovf_clr_i) m_ovf = 0;

    m_done = 0;
    m_err  = 0;
    if (m_boot) begin
      m_boot = 0; m_seq = 0; m_from_boot = 1;
    end else if (m_seq >= 0) begin
      if (m_seq == 3*H - 1) begin
        m_seq = -1; m_done = !m_from_boot; m_from_boot = 0;
      end else m_seq++;
    end else if (m_wait >= 0) begin
      if (bus.rx_ready_i) begin
        m_baud = m_req; m_wait = -1; m_seq = 0;
      end else if (m_wait == TMO - 1) begin
        m_err = 1; m_wait = -1;
      end else m_wait++;
    end else if (bus.cfg_valid_i) begin
      if (bus.cfg_baud_i == 0 || bus.cfg_baud_i > MAXB) m_err = 1;
      else begin m_req = bus.cfg_baud_i; m_wait = 0; end
    end
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    chk1("cfg_ready", bus.cfg_ready_o, !m_boot && m_seq < 0 && m_wait < 0);
    chk1("cfg_done",  bus.cfg_done_o,  m_done);
    chk1("cfg_err",   bus.cfg_err_o,   m_err);
    chk32("baud_rate", bus.baud_rate_o, m_baud);
    chk1("baud_we",   bus.baud_we_o,   m_seq >= 0 && m_seq < H);
    chk1("baud_rd",   bus.baud_rd_o,   m_seq >= H && m_seq < 2*H);
    chk1("rd_valid",  bus.rd_valid_o,  m_q.size() > 0);
    if (m_q.size() > 0) chk32("rd_data", 32'(bus.rd_data_o), 32'(m_q[0]));
    chk1("ovf", bus.ovf_o, m_ovf);
    if (!rst) model_step();
  end

  // -------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!bus.cfg_ready_o && i < 64);
    chk1("reach_idle", bus.cfg_ready_o, 1'b1);
  endtask

  task automatic cfg_req(input logic [31:0] b, input logic rdy);
    tick();
    bus.rx_ready_i  = rdy;
    bus.cfg_valid_i = 1'b1;
    bus.cfg_baud_i  = b;
    tick();
    bus.cfg_valid_i = 1'b0;
  endtask

  // Samples n cycles; index 0 is the first falling edge after the call.
  task automatic observe(input int n, output int we_c, output int rd_c,
                         output int dn_c, output int er_c, output int we_i,
                         output int dn_i, output int er_i, output logic [31:0] baud_we);
    we_c = 0; rd_c = 0; dn_c = 0; er_c = 0;
    we_i = -1; dn_i = -1; er_i = -1; baud_we = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.baud_we_o) begin
        if (we_i < 0) begin we_i = i; baud_we = bus.baud_rate_o; end
        we_c++;
      end
      if (bus.baud_rd_o) rd_c++;
      if (bus.cfg_done_o) begin if (dn_i < 0) dn_i = i; dn_c++; end
      if (bus.cfg_err_o)  begin if (er_i < 0) er_i = i; er_c++; end
    end
  endtask

  task automatic check_reset_values();
    chk32("rst_baud",  bus.baud_rate_o, DEF_BAUD);
    chk1("rst_we",     bus.baud_we_o,   1'b0);
    chk1("rst_rd",     bus.baud_rd_o,   1'b0);
    chk1("rst_ready",  bus.cfg_ready_o, 1'b0);
    chk1("rst_valid",  bus.rd_valid_o,  1'b0);
    chk1("rst_ovf",    bus.ovf_o,       1'b0);
    chk32("rst_rdata", 32'(bus.rd_data_o), 32'd0);
  endtask

  task automatic boot_check();
    int we_c, rd_c, dn_c, er_c, we_i, dn_i, er_i;
    logic [31:0] b;
    observe(16, we_c, rd_c, dn_c, er_c, we_i, dn_i, er_i, b);
    chk32("boot_we_start", we_i, 1);
    chk32("boot_we_cycles", we_c, 4);
    chk32("boot_rd_cycles", rd_c, 4);
    chk32("boot_done_cnt", dn_c, 0);
    chk32("boot_baud", b, DEF_BAUD);
    chk1("boot_ready", bus.cfg_ready_o, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int hold);
    tick();
    bus.rx_done_i = 1'b1;
    bus.rx_data_i = d;
    repeat (hold) tick();
    bus.rx_done_i = 1'b0;
  endtask

  task automatic pop();
    tick();
    bus.rd_ready_i = 1'b1;
    tick();
    bus.rd_ready_i = 1'b0;
  endtask

  task automatic pop_check(input logic [7:0] exp);
    @(negedge clk);
    chk1("drain_valid", bus.rd_valid_o, 1'b1);
    chk32("drain_data", 32'(bus.rd_data_o), 32'(exp));
    pop();
  endtask

  initial begin
    int we_c, rd_c, dn_c, er_c, we_i, dn_i, er_i;
    logic [31:0] b;
    bus.cfg_valid_i = 1'b0; bus.cfg_baud_i = '0; bus.rx_ready_i = 1'b1;
    bus.rx_done_i = 1'b0; bus.rx_data_i = '0; bus.rd_ready_i = 1'b0;
    bus.ovf_clr_i = 1'b0;
    rst = 1'b1;

    // 1. reset and boot sequence
    repeat (2) @(negedge clk);
    check_reset_values();
    tick();
    rst = 1'b0;
    boot_check();

    // 2. accepted request, receiver idle
    wait_idle();
    cfg_req(32'd9600, 1'b1);
    observe(20, we_c, rd_c, dn_c, er_c, we_i, dn_i, er_i, b);
    chk32("req_we_start", we_i, 1);
    chk32("req_baud", b, 32'd9600);
    chk32("req_we_cycles", we_c, 4);
    chk32("req_rd_cycles", rd_c, 4);
    chk32("req_done_cnt", dn_c, 1);
    chk32("req_done_delay", dn_i - we_i, 12);

    // 3. rejected requests and the inclusive upper bound
    wait_idle();
    cfg_req(32'd0, 1'b1);
    observe(6, we_c, rd_c, dn_c, er_c, we_i, dn_i, er_i, b);
    chk32("zero_err_cnt", er_c, 1);
    chk32("zero_err_at", er_i, 0);
    chk32("zero_we", we_c, 0);
    chk32("zero_baud", bus.baud_rate_o, 32'd9600);
    wait_idle();
    cfg_req(32'd25_000_001, 1'b1);
    observe(6, we_c, rd_c, dn_c, er_c, we_i, dn_i, er_i, b);
    chk32("high_err_cnt", er_c, 1);
    chk32("high_we", we_c, 0);
    chk32("high_baud", bus.baud_rate_o, 32'd9600);
    wait_idle();
    cfg_req(32'd25_000_000, 1'b1);
    observe(20, we_c, rd_c, dn_c, er_c, we_i, dn_i, er_i, b);
    chk32("max_err_cnt", er_c, 0);
    chk32("max_done_cnt", dn_c, 1);
    chk32("max_baud", b, 32'd25_000_000);

    // 4. receiver never idle: timeout
    wait_idle();
    cfg_req(32'd19200, 1'b0);
    observe(30, we_c, rd_c, dn_c, er_c, we_i, dn_i, er_i, b);
    chk32("tmo_err_cnt", er_c, 1);
    chk32("tmo_err_at", er_i, 16);
    chk32("tmo_we", we_c, 0);
    chk32("tmo_baud", bus.baud_rate_o, 32'd25_000_000);
    chk1("tmo_ready", bus.cfg_ready_o, 1'b1);
    bus.rx_ready_i = 1'b1;

    // 5. long DONE level gives one entry
    send_frame(8'hA5, 50);
    @(negedge clk);
    chk1("frm_valid", bus.rd_valid_o, 1'b1);
    chk32("frm_data", 32'(bus.rd_data_o), 32'hA5);
    pop();
    @(negedge clk);
    chk1("frm_popped", bus.rd_valid_o, 1'b0);

    // 6. overflow, clear, pop+push at full, drain, pop on empty
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 2);
    @(negedge clk);
    chk1("ovf_set", bus.ovf_o, 1'b1);
    chk32("ovf_head", 32'(bus.rd_data_o), 32'h01);
    tick();
    bus.ovf_clr_i = 1'b1;
    tick();
    bus.ovf_clr_i = 1'b0;
    @(negedge clk);
    chk1("ovf_cleared", bus.ovf_o, 1'b0);
    tick();
    bus.rx_done_i = 1'b1; bus.rx_data_i = 8'h06; bus.rd_ready_i = 1'b1;
    tick();
    bus.rx_done_i = 1'b0; bus.rd_ready_i = 1'b0;
    @(negedge clk);
    chk1("pp_no_ovf", bus.ovf_o, 1'b0);
    pop_check(8'h02);
    pop_check(8'h03);
    pop_check(8'h04);
    pop_check(8'h06);
    pop();
    @(negedge clk);
    chk1("empty_pop", bus.rd_valid_o, 1'b0);
    for (int k = 7; k <= 10; k++) send_frame(8'(k), 2);
    tick();
    bus.rx_done_i = 1'b1; bus.rx_data_i = 8'h0B; bus.ovf_clr_i = 1'b1;
    tick();
    bus.rx_done_i = 1'b0; bus.ovf_clr_i = 1'b0;
    @(negedge clk);
    chk1("clr_vs_ovf", bus.ovf_o, 1'b1);

    // 7. reset in the middle of a write sequence
    wait_idle();
    cfg_req(32'd9600, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    tick();
    rst = 1'b0;
    boot_check();

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
